// File: rtl/map_fetch.sv
// Streams the rows of one map ROM bank to a ready/valid consumer, forward or reverse.
// Each row takes an address cycle, a capture cycle and a hold cycle that waits for the consumer.
module map_fetch #(
  parameter int NUM_MAPS = 3,
  parameter int ROW_W    = 8,
  parameter int ROWS     = 8,
  localparam int SEL_W   = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1,
  localparam int ADDR_W  = $clog2(ROWS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [SEL_W-1:0]          map_sel,
  input  logic                      reverse,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [NUM_MAPS*ROW_W-1:0] rom_data,
  output logic [ROW_W-1:0]          row_data,
  output logic [ADDR_W-1:0]         row_idx,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CAPT,
    HOLD,
    FIN
  } state_t;

  localparam logic [SEL_W:0]    MAP_LIMIT = (SEL_W + 1)'(NUM_MAPS);
  localparam logic [ADDR_W-1:0] LAST_FWD  = ADDR_W'(ROWS - 1);

  state_t              state;
  state_t              state_nxt;
  logic [SEL_W-1:0]    sel_q;
  logic                rev_q;
  logic [ADDR_W-1:0]   ctr;
  logic [ADDR_W-1:0]   ctr_step;
  logic [ROW_W-1:0]    bank_row;
  logic                sel_ok;
  logic                accept;
  logic                last_row;

  // One extra bit keeps the compare honest when NUM_MAPS is a power of two.
  assign sel_ok   = ({1'b0, map_sel} < MAP_LIMIT);
  assign accept   = (state == HOLD) && row_valid && row_ready;
  assign last_row = rev_q ? (ctr == '0) : (ctr == LAST_FWD);
  assign ctr_step = rev_q ? (ctr - ADDR_W'(1)) : (ctr + ADDR_W'(1));

  assign busy = (state != IDLE);
  assign done = (state == FIN);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    bank_row = '0;
    for (int k = 0; k < NUM_MAPS; k++) begin
      if (sel_q == SEL_W'(k)) begin
        bank_row = rom_data[k*ROW_W +: ROW_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start && sel_ok) state_nxt = ADDR;
      ADDR: state_nxt = CAPT;
      CAPT: state_nxt = HOLD;
      HOLD: if (accept) state_nxt = last_row ? FIN : ADDR;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rom_addr is loaded on entry to ADDR so the banks see it for the whole ADDR cycle;
  // their registered read then lands on rom_data during CAPT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= '0;
      rev_q     <= 1'b0;
      ctr       <= '0;
      rom_addr  <= '0;
      row_data  <= '0;
      row_idx   <= '0;
      row_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (sel_ok) begin
              sel_q    <= map_sel;
              rev_q    <= reverse;
              ctr      <= reverse ? LAST_FWD : '0;
              rom_addr <= reverse ? LAST_FWD : '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        CAPT: begin
          row_data  <= bank_row;
          row_idx   <= ctr;
          row_valid <= 1'b1;
        end
        HOLD: begin
          if (accept) begin
            row_valid <= 1'b0;
            if (!last_row) begin
              ctr      <= ctr_step;
              rom_addr <= ctr_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_map_fetch.sv
// Bench for map_fetch: a cycle vector table for the opening cycles, then whole-fetch
// sequences (forward, reverse, backpressure, start-while-busy, reset mid-fetch).
module tb_map_fetch;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  map_sel;
  logic        reverse;
  logic [2:0]  rom_addr;
  logic [23:0] rom_data;
  logic [7:0]  row_data;
  logic [2:0]  row_idx;
  logic        row_valid;
  logic        row_ready;
  logic        busy;
  logic        done;
  logic        err;

  int checks;
  int errors;

  map_fetch #(.NUM_MAPS(3), .ROW_W(8), .ROWS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .map_sel   (map_sel),
    .reverse   (reverse),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .row_data  (row_data),
    .row_idx   (row_idx),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bank_base(input int k);
    case (k)
      0:       return 8'h50;
      1:       return 8'h10;
      default: return 8'hA0;
    endcase
  endfunction

  // Three synchronous-read banks: bank k row r holds bank_base(k) + r.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      rom_data[k*8 +: 8] <= bank_base(k) + {5'b0, rom_addr};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {14'd0, busy, row_valid, done, err, rom_addr, row_idx, row_data};
  endfunction

  typedef struct {
    logic       rst;
    logic       start;
    logic [1:0] sel;
    logic       rev;
    logic       rdy;
    logic       busy;
    logic       valid;
    logic       done;
    logic       err;
    logic [2:0] addr;
    logic [2:0] idx;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic s, input logic [1:0] sl, input logic rv,
                              input logic rd, input logic b, input logic v, input logic d,
                              input logic e, input logic [2:0] a, input logic [2:0] i,
                              input logic [7:0] dt);
    vec_t t;
    t.rst = r;  t.start = s; t.sel = sl;  t.rev = rv; t.rdy = rd;
    t.busy = b; t.valid = v; t.done = d;  t.err = e;  t.addr = a; t.idx = i; t.data = dt;
    vecs.push_back(t);
  endfunction

  task automatic run_fetch(input logic [1:0] sel, input logic rev, input int stall_row,
                           input int stall_len, input int poke_row, input string tag);
    int cycles, busy_cnt, done_cnt, err_cnt, first_valid, stall_left;
    logic [10:0] snap;
    logic [2:0]  got_idx[$];
    logic [7:0]  got_data[$];
    logic [2:0]  exp_idx;
    cycles = 1; busy_cnt = 0; done_cnt = 0; err_cnt = 0; first_valid = -1;
    stall_left = stall_len; snap = '0;
    start = 1'b1; map_sel = sel; reverse = rev; row_ready = 1'b1;
    step();
    map_sel = ~sel;
    reverse = ~rev;
    while ((busy || done_cnt == 0) && cycles < 200) begin
      if (busy && !done) busy_cnt++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (row_valid && first_valid < 0) first_valid = cycles;
      start = 1'b0;
      row_ready = 1'b1;
      if (row_valid) begin
        if (int'(row_idx) == stall_row && stall_left > 0) begin
          if (stall_left == stall_len) snap = {row_idx, row_data};
          else check($sformatf("%s_hold_stable", tag), {21'd0, row_idx, row_data}, {21'd0, snap});
          row_ready = 1'b0;
          stall_left--;
        end else begin
          if (int'(row_idx) == stall_row && stall_len > 0)
            check($sformatf("%s_hold_stable", tag), {21'd0, row_idx, row_data}, {21'd0, snap});
          got_idx.push_back(row_idx);
          got_data.push_back(row_data);
        end
        if (int'(row_idx) == poke_row) start = 1'b1;
      end
      step();
      cycles++;
    end
    start = 1'b0;
    map_sel = '0;
    reverse = 1'b0;
    check($sformatf("%s_timeout", tag), 32'(cycles < 200), 32'd1);
    check($sformatf("%s_first_valid_edges", tag), 32'(first_valid), 32'd3);
    check($sformatf("%s_done_pulses", tag), 32'(done_cnt), 32'd1);
    check($sformatf("%s_err_pulses", tag), 32'(err_cnt), 32'd0);
    check($sformatf("%s_busy_cycles", tag), 32'(busy_cnt), 32'(24 + stall_len));
    check($sformatf("%s_row_count", tag), 32'(got_idx.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_idx.size(); i++) begin
      exp_idx = rev ? 3'(7 - i) : 3'(i);
      check($sformatf("%s_row%0d", tag, i), {21'd0, got_idx[i], got_data[i]},
            {21'd0, exp_idx, bank_base(int'(sel)) + {5'b0, exp_idx}});
    end
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst = 1'b1; start = 1'b0; map_sel = '0; reverse = 1'b0; row_ready = 1'b0;
    step();
    step();
    check("reset_outputs", outs(), 32'd0);

    //   rst start sel rev rdy | busy valid done err addr idx data
    add(0, 1, 3, 0, 1,  0, 0, 0, 1, 0, 0, 8'h00);  // bad select rejected
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 8'h00);  // err is a single pulse
    add(0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 8'h00);  // ADDR row 0
    add(0, 0, 2, 1, 1,  1, 0, 0, 0, 0, 0, 8'h00);  // CAPT, ready ignored, sel change ignored
    add(0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 8'h10);  // HOLD row 0, start ignored
    add(0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 8'h10);  // stalled
    add(0, 0, 0, 0, 1,  1, 0, 0, 0, 1, 0, 8'h10);  // accepted, ADDR row 1
    add(0, 0, 0, 0, 1,  1, 0, 0, 0, 1, 0, 8'h10);  // CAPT
    add(0, 0, 0, 0, 1,  1, 1, 0, 0, 1, 1, 8'h11);  // HOLD row 1
    add(1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 8'h00);  // reset
    add(0, 1, 2, 1, 1,  1, 0, 0, 0, 7, 0, 8'h00);  // start on first edge after reset, reverse
    add(0, 0, 0, 0, 1,  1, 0, 0, 0, 7, 0, 8'h00);  // CAPT
    add(0, 0, 0, 0, 1,  1, 1, 0, 0, 7, 7, 8'hA7);  // HOLD row 7
    add(0, 0, 0, 0, 1,  1, 0, 0, 0, 6, 7, 8'hA7);  // ADDR row 6
    add(1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 8'h00);  // reset

    for (int v = 0; v < vecs.size(); v++) begin
      rst = vecs[v].rst; start = vecs[v].start; map_sel = vecs[v].sel;
      reverse = vecs[v].rev; row_ready = vecs[v].rdy;
      step();
      check($sformatf("vec%0d", v), outs(),
            {14'd0, vecs[v].busy, vecs[v].valid, vecs[v].done, vecs[v].err,
             vecs[v].addr, vecs[v].idx, vecs[v].data});
    end
    rst = 1'b0; start = 1'b0; map_sel = '0; reverse = 1'b0; row_ready = 1'b1;
    step();

    run_fetch(2'd1, 1'b0, -1, 0, -1, "fwd");
    run_fetch(2'd2, 1'b1, -1, 0, -1, "rev");
    run_fetch(2'd1, 1'b0, 3, 5, 2, "stall");

    start = 1'b1; map_sel = 2'd1; reverse = 1'b0; row_ready = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(row_valid && row_idx == 3'd4) && n < 100) begin
      step();
      n++;
    end
    check("reach_row4", 32'(n < 100), 32'd1);
    row_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check("reset_async", outs(), 32'd0);
    step();
    check("reset_held", outs(), 32'd0);
    rst = 1'b0;
    run_fetch(2'd2, 1'b0, -1, 0, -1, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
